// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses HEADER/ADDR/DATA/CSUM frames from a UART byte stream,
// commits valid writes to a 4 x 8-bit register space and counts rejected frames.
module uart_cmd_ctrl #(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] led_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d, ok_q, ok_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d, led_q, led_d, err_cnt_q, err_cnt_d;
  logic          tmo, good, acc, rej;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      led_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      led_q     <= led_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // A strobe on the terminal-count cycle takes priority over the timeout.
  always_comb begin
    tmo     = (state_q != IDLE) && !rx_done && (cnt_q == TC);
    state_d = state_q;
    if (rx_done) begin
      unique case (state_q)
        IDLE:    state_d = (rx_data == HEADER) ? ADDR : IDLE;
        ADDR:    state_d = DATA;
        DATA:    state_d = CSUM;
        default: state_d = IDLE;
      endcase
    end else if (tmo) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    good      = (rx_data == 8'(addr_q + data_q)) && (addr_q[7:2] == 6'd0);
    acc       = rx_done && (state_q == CSUM) && good;
    rej       = (rx_done && (state_q == CSUM) && !good) || tmo;
    addr_d    = (rx_done && state_q == ADDR) ? rx_data : addr_q;
    data_d    = (rx_done && state_q == DATA) ? rx_data : data_q;
    cnt_d     = (rx_done || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    wr_en_d   = acc;
    ok_d      = acc;
    err_d     = rej;
    wr_addr_d = acc ? addr_q[1:0] : wr_addr_q;
    wr_data_d = acc ? data_q : wr_data_q;
    led_d     = (acc && addr_q[1:0] == 2'd0) ? data_q : led_q;
    err_cnt_d = (rej && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    busy_d    = state_d != IDLE;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign led_data  = led_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: frame-level model (byte queue + strobe timestamps) checked
// against the DUT every cycle, plus hand-computed checks of the directed frames.
module tb_uart_cmd_ctrl;
  localparam int T = 16;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       wr_en, frame_ok, frame_err, busy;
  logic [1:0] wr_addr;
  logic [7:0] wr_data, led_data, err_cnt;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .led_data(led_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_ok = 0, n_err = 0, n_wr = 0, last_wa = -1, last_wd = -1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is a queue of bytes started by HDR; a frame is judged when
  // its fourth byte arrives or when T cycles pass without a byte.
  int fr[$];
  int cyc = 0, last = 0;
  int m_wr = 0, m_ok = 0, m_err = 0, m_wa = 0, m_wd = 0, m_led = 0, m_cnt = 0, m_busy = 0;

  task automatic m_reject();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
    fr = {};
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      fr = {};
      {m_wr, m_ok, m_err, m_wa, m_wd, m_led, m_cnt, m_busy} = '0;
    end else begin
      cyc++;
      {m_wr, m_ok, m_err} = '0;
      if (rx_done) begin
        last = cyc;
        if (fr.size() > 0 || rx_data == HDR) fr.push_back(int'(rx_data));
        if (fr.size() == 4) begin
          if (fr[3] == ((fr[1] + fr[2]) % 256) && fr[1] < 4) begin
            m_wr = 1; m_ok = 1; m_wa = fr[1]; m_wd = fr[2];
            if (fr[1] == 0) m_led = fr[2];
            fr = {};
          end else m_reject();
        end
      end else if (fr.size() > 0 && cyc - last == T) m_reject();
      m_busy = int'(fr.size() > 0);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("wr_en", int'(wr_en), m_wr);
    chk("frame_ok", int'(frame_ok), m_ok);
    chk("frame_err", int'(frame_err), m_err);
    chk("wr_addr", int'(wr_addr), m_wa);
    chk("wr_data", int'(wr_data), m_wd);
    chk("led_data", int'(led_data), m_led);
    chk("err_cnt", int'(err_cnt), m_cnt);
    chk("busy", int'(busy), m_busy);
    n_ok += int'(frame_ok);
    n_err += int'(frame_err);
    if (wr_en) begin n_wr++; last_wa = int'(wr_addr); last_wd = int'(wr_data); end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(1);
    rx_done = 1'b0; tick(1);
  endtask

  task automatic send4(logic [7:0] h, logic [7:0] a, logic [7:0] d, logic [7:0] s);
    send(h); send(a); send(d); send(s);
  endtask

  int ok0, err0, wr0, k;

  initial begin
    #2 rst_n = 1'b0;
    tick(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    tick(2);

    send4(8'hA5, 8'h00, 8'h3C, 8'h3C);
    chk("f1_ok_count", n_ok, 1);
    chk("f1_wr_count", n_wr, 1);
    chk("f1_led", int'(led_data), 'h3C);
    chk("f1_err_cnt", int'(err_cnt), 0);

    send4(8'hA5, 8'h02, 8'hF0, 8'hF2);
    chk("f2_wa", last_wa, 2);
    chk("f2_wd", last_wd, 'hF0);
    chk("f2_led_held", int'(led_data), 'h3C);
    wr0 = n_wr;
    send4(8'hA5, 8'h02, 8'hF0, 8'h20);
    chk("f3_err_count", n_err, 1);
    chk("f3_err_cnt", int'(err_cnt), 1);
    chk("f3_no_wr", n_wr, wr0);

    send4(8'hA5, 8'h07, 8'h01, 8'h08);
    chk("badaddr_err_cnt", int'(err_cnt), 2);
    chk("badaddr_busy", int'(busy), 0);
    chk("badaddr_no_wr", n_wr, wr0);

    err0 = n_err;
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("garbage_busy", int'(busy), 0);
    chk("garbage_no_err", n_err, err0);
    send4(8'hA5, 8'h01, 8'h11, 8'h12);
    chk("f5_wa", last_wa, 1);
    chk("f5_wd", last_wd, 'h11);

    send(8'hA5);
    rx_data = 8'h03; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    k = 0;
    while (!frame_err && k < 100) begin tick(1); k++; end
    chk("timeout_delay", k, T);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_err_cnt", int'(err_cnt), 3);
    tick(1);
    send4(8'hA5, 8'h00, 8'h55, 8'h55);
    chk("post_timeout_led", int'(led_data), 'h55);

    err0 = n_err; ok0 = n_ok;
    send(8'hA5);
    rx_data = 8'h03; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    tick(T - 1);
    rx_data = 8'h10; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    tick(3);
    chk("tc_strobe_no_err", n_err, err0);
    chk("tc_strobe_busy", int'(busy), 1);
    send(8'h13);
    chk("tc_frame_ok", n_ok, ok0 + 1);
    chk("tc_frame_wd", last_wd, 'h10);

    for (int i = 0; i < 300; i++) send4(8'hA5, 8'h01, 8'h01, 8'h00);
    chk("sat_err_cnt", int'(err_cnt), 'hFF);

    send(8'hA5); send(8'h01);
    ok0 = n_ok; err0 = n_err;
    rst_n = 1'b0; tick(2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_led", int'(led_data), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    rst_n = 1'b1; tick(2);
    chk("rst_no_pulse", n_ok + n_err, ok0 + err0);
    send4(8'hA5, 8'h00, 8'h77, 8'h77);
    chk("post_rst_ok", n_ok, ok0 + 1);
    chk("post_rst_led", int'(led_data), 'h77);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
